// File: rtl/ofs_fim_ace_lite_slv_pkg.sv
// rtl/ofs_fim_ace_lite_slv_pkg.sv - response/burst codes and FSM state types for the ACE-Lite memory responder
package ofs_fim_ace_lite_slv_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

endpackage

// File: rtl/ofs_fim_ace_lite_if.sv
// rtl/ofs_fim_ace_lite_if.sv - ACE-Lite five-channel bundle with master and slave views
interface ofs_fim_ace_lite_if #(
   parameter int AWADDR_WIDTH = 32,
   parameter int ARADDR_WIDTH = 32,
   parameter int WDATA_WIDTH  = 512,
   parameter int RDATA_WIDTH  = 512,
   parameter int ID_WIDTH     = 4,
   parameter int USER_WIDTH   = 1
);
   logic [ID_WIDTH-1:0]      awid;
   logic [AWADDR_WIDTH-1:0]  awaddr;
   logic [7:0]               awlen;
   logic [2:0]               awsize;
   logic [1:0]               awburst;
   logic                     awlock;
   logic [3:0]               awcache;
   logic [2:0]               awprot;
   logic [3:0]               awqos;
   logic [USER_WIDTH-1:0]    awuser;
   logic [2:0]               awsnoop;
   logic [1:0]               awdomain;
   logic [1:0]               awbar;
   logic                     awvalid;
   logic                     awready;

   logic [WDATA_WIDTH-1:0]   wdata;
   logic [WDATA_WIDTH/8-1:0] wstrb;
   logic                     wlast;
   logic                     wvalid;
   logic                     wready;

   logic [ID_WIDTH-1:0]      bid;
   logic [1:0]               bresp;
   logic                     bvalid;
   logic                     bready;

   logic [ID_WIDTH-1:0]      arid;
   logic [ARADDR_WIDTH-1:0]  araddr;
   logic [7:0]               arlen;
   logic [2:0]               arsize;
   logic [1:0]               arburst;
   logic                     arlock;
   logic [3:0]               arcache;
   logic [2:0]               arprot;
   logic [3:0]               arqos;
   logic [USER_WIDTH-1:0]    aruser;
   logic [3:0]               arsnoop;
   logic [1:0]               ardomain;
   logic [1:0]               arbar;
   logic                     arvalid;
   logic                     arready;

   logic [ID_WIDTH-1:0]      rid;
   logic [RDATA_WIDTH-1:0]   rdata;
   logic [1:0]               rresp;
   logic                     rlast;
   logic                     rvalid;
   logic                     rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser,
             awsnoop, awdomain, awbar, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
             arsnoop, ardomain, arbar, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser,
             awsnoop, awdomain, awbar, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
             arsnoop, ardomain, arbar, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

endinterface

// File: rtl/ofs_fim_ace_lite_slv_ram.sv
// rtl/ofs_fim_ace_lite_slv_ram.sv - DEPTH x DATA_WIDTH byte-enabled array, one write port, one async read port
module ofs_fim_ace_lite_slv_ram #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 512
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_WIDTH/8-1:0]    wstrb_i,
   input  logic [DATA_WIDTH-1:0]      wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]      rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Contents are deliberately never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ofs_fim_ace_lite_slv_mem.sv
// rtl/ofs_fim_ace_lite_slv_mem.sv - ACE-Lite responder backed by a DEPTH-line RAM
// Optional response checking: OFS_ACE_LITE_SLV_ERR_CHK_EN
module ofs_fim_ace_lite_slv_mem
   import ofs_fim_ace_lite_slv_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 4
) (
   input logic               clk,
   input logic               rst,
   ofs_fim_ace_lite_if.slave s_ace
);
   localparam int LSB   = $clog2(DATA_WIDTH/8);
   localparam int IDX_W = $clog2(DEPTH);

   wr_state_e             w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   awid_q, awid_d;
   logic [IDX_W-1:0]      w_idx_q, w_idx_d;
   logic [7:0]            w_len_q, w_len_d;
   logic [7:0]            w_cnt_q, w_cnt_d;
   logic                  w_err_q, w_err_d;
   logic                  w_lerr_q, w_lerr_d;
   logic [1:0]            bresp_q, bresp_d;

   rd_state_e             r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   arid_q, arid_d;
   logic [IDX_W-1:0]      r_idx_q, r_idx_d;
   logic [7:0]            r_len_q, r_len_d;
   logic [7:0]            r_cnt_q, r_cnt_d;
   logic                  r_err_q, r_err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  ram_we;
   logic [IDX_W-1:0]      ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [IDX_W-1:0]      aw_idx, ar_idx;
   logic                  aw_err, ar_err, wlast_bad;

   assign aw_idx = s_ace.awaddr[LSB +: IDX_W];
   assign ar_idx = s_ace.araddr[LSB +: IDX_W];

`ifdef OFS_ACE_LITE_SLV_ERR_CHK_EN
   localparam int         SPAN_W    = LSB + IDX_W;
   localparam logic [2:0] SIZE_LOG2 = 3'(LSB);
   assign aw_err    = (s_ace.awburst != BURST_INCR) || (s_ace.awsize != SIZE_LOG2) ||
                      ((s_ace.awaddr >> SPAN_W) != '0);
   assign ar_err    = (s_ace.arburst != BURST_INCR) || (s_ace.arsize != SIZE_LOG2) ||
                      ((s_ace.araddr >> SPAN_W) != '0);
   assign wlast_bad = s_ace.wlast != (w_cnt_q == w_len_q);
`else
   assign aw_err    = 1'b0;
   assign ar_err    = 1'b0;
   assign wlast_bad = 1'b0;
`endif

   always_comb begin
      w_state_d = w_state_q;
      awid_d    = awid_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_lerr_d  = w_lerr_q;
      bresp_d   = bresp_q;
      ram_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (s_ace.awvalid) begin
            w_state_d = W_DATA;
            awid_d    = s_ace.awid;
            w_idx_d   = aw_idx;
            w_len_d   = s_ace.awlen;
            w_cnt_d   = '0;
            w_err_d   = aw_err;
            w_lerr_d  = 1'b0;
         end
         W_DATA: if (s_ace.wvalid) begin
            // A reset edge abandons the burst, so the coincident beat must not land.
            ram_we  = !w_err_q && !rst;
            w_idx_d = w_idx_q + 1'b1;
            w_cnt_d = w_cnt_q + 1'b1;
            if (w_cnt_q == w_len_q) begin
               w_state_d = W_RESP;
               bresp_d   = (w_err_q || w_lerr_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
               w_lerr_d  = w_lerr_q || wlast_bad;
            end
         end
         W_RESP: if (s_ace.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read data is registered one beat ahead so stalls hold it even if the line is rewritten.
   assign ram_raddr = (r_state_q == R_IDLE) ? ar_idx : r_idx_q + 1'b1;

   always_comb begin
      r_state_d = r_state_q;
      arid_d    = arid_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_err_d   = r_err_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: if (s_ace.arvalid) begin
            r_state_d = R_DATA;
            arid_d    = s_ace.arid;
            r_idx_d   = ar_idx;
            r_len_d   = s_ace.arlen;
            r_cnt_d   = '0;
            r_err_d   = ar_err;
            rdata_d   = ar_err ? '0 : ram_rdata;
         end
         R_DATA: if (s_ace.rready) begin
            if (r_cnt_q == r_len_q) begin
               r_state_d = R_IDLE;
               rdata_d   = '0;
            end else begin
               r_idx_d   = r_idx_q + 1'b1;
               r_cnt_d   = r_cnt_q + 1'b1;
               rdata_d   = r_err_q ? '0 : ram_rdata;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awid_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_lerr_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         r_state_q <= R_IDLE;
         arid_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         awid_q    <= awid_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_lerr_q  <= w_lerr_d;
         bresp_q   <= bresp_d;
         r_state_q <= r_state_d;
         arid_q    <= arid_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_err_q   <= r_err_d;
         rdata_q   <= rdata_d;
      end
   end

   ofs_fim_ace_lite_slv_ram #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (w_idx_q),
      .wstrb_i (s_ace.wstrb),
      .wdata_i (s_ace.wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   assign s_ace.awready = (w_state_q == W_IDLE);
   assign s_ace.wready  = (w_state_q == W_DATA);
   assign s_ace.bvalid  = (w_state_q == W_RESP);
   assign s_ace.bid     = awid_q;
   assign s_ace.bresp   = (w_state_q == W_RESP) ? bresp_q : RESP_OKAY;

   assign s_ace.arready = (r_state_q == R_IDLE);
   assign s_ace.rvalid  = (r_state_q == R_DATA);
   assign s_ace.rid     = arid_q;
   assign s_ace.rdata   = rdata_q;
   assign s_ace.rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
   assign s_ace.rresp   = ((r_state_q == R_DATA) && r_err_q) ? RESP_SLVERR : RESP_OKAY;

   logic unused_ok;
   assign unused_ok = ^{s_ace.awprot, s_ace.awcache, s_ace.awqos, s_ace.awuser, s_ace.awlock,
                        s_ace.awsnoop, s_ace.awdomain, s_ace.awbar, s_ace.awburst, s_ace.awsize,
                        s_ace.awaddr, s_ace.wlast,
                        s_ace.arprot, s_ace.arcache, s_ace.arqos, s_ace.aruser, s_ace.arlock,
                        s_ace.arsnoop, s_ace.ardomain, s_ace.arbar, s_ace.arburst, s_ace.arsize,
                        s_ace.araddr};

endmodule

// File: tb/tb_ofs_fim_ace_lite_slv_mem.sv
// tb/tb_ofs_fim_ace_lite_slv_mem.sv - directed self-checking bench for ofs_fim_ace_lite_slv_mem
module tb_ofs_fim_ace_lite_slv_mem;
   import ofs_fim_ace_lite_slv_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 32;
   localparam int DW    = 512;
   localparam int IDW   = 4;
   localparam int NB    = DW/8;
`ifdef OFS_ACE_LITE_SLV_ERR_CHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   typedef logic [DW-1:0] line_t;

   logic  clk = 1'b0;
   logic  rst;
   int    n_cmp = 0;
   int    n_err = 0;
   line_t model [DEPTH];
   line_t last_rdata;

   always #5 clk = ~clk;

   ofs_fim_ace_lite_if #(
      .AWADDR_WIDTH (AW), .ARADDR_WIDTH (AW),
      .WDATA_WIDTH  (DW), .RDATA_WIDTH  (DW), .ID_WIDTH (IDW)
   ) ace ();

   ofs_fim_ace_lite_slv_mem #(
      .DEPTH (DEPTH), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IDW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .s_ace (ace)
   );

   function automatic line_t pat(input logic [7:0] b);
      return {NB{b}};
   endfunction

   task automatic chk(input string tag, input line_t obs, input line_t expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idle_bus();
      ace.awid = '0; ace.awaddr = '0; ace.awlen = '0; ace.awsize = 3'd6; ace.awburst = BURST_INCR;
      ace.awlock = '0; ace.awcache = '0; ace.awprot = '0; ace.awqos = '0; ace.awuser = '0;
      ace.awsnoop = '0; ace.awdomain = '0; ace.awbar = '0; ace.awvalid = 1'b0;
      ace.wdata = '0; ace.wstrb = '0; ace.wlast = 1'b0; ace.wvalid = 1'b0; ace.bready = 1'b0;
      ace.arid = '0; ace.araddr = '0; ace.arlen = '0; ace.arsize = 3'd6; ace.arburst = BURST_INCR;
      ace.arlock = '0; ace.arcache = '0; ace.arprot = '0; ace.arqos = '0; ace.aruser = '0;
      ace.arsnoop = '0; ace.ardomain = '0; ace.arbar = '0; ace.arvalid = 1'b0; ace.rready = 1'b0;
   endtask

   task automatic do_write(input string tag, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input logic [1:0] burst, input logic [7:0] base,
                           input logic [NB-1:0] strb, input bit early_last,
                           input logic [1:0] exp_resp, input bit upd);
      int idx, t;
      idx = int'(addr[9:6]);
      ace.awid = id; ace.awaddr = addr; ace.awlen = 8'(len); ace.awburst = burst; ace.awvalid = 1'b1;
      t = 0;
      while (ace.awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      chk({tag, "_aw_timeout"}, line_t'(t < 50), 1);
      @(posedge clk); #1;
      ace.awvalid = 1'b0; ace.awburst = BURST_INCR;
      for (int b = 0; b <= len; b++) begin
         ace.wdata = pat(base + 8'(b)); ace.wstrb = strb;
         ace.wlast = early_last ? (b == 0) : (b == len); ace.wvalid = 1'b1;
         t = 0;
         while (ace.wready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
         chk({tag, "_w_timeout"}, line_t'(t < 50), 1);
         @(posedge clk); #1;
         if (upd) for (int k = 0; k < NB; k++)
            if (strb[k]) model[(idx + b) % DEPTH][k*8 +: 8] = base + 8'(b);
      end
      ace.wvalid = 1'b0; ace.wlast = 1'b0; ace.bready = 1'b1;
      t = 0;
      while (ace.bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      chk({tag, "_b_timeout"}, line_t'(t < 50), 1);
      chk({tag, "_bid"}, ace.bid, id);
      chk({tag, "_bresp"}, ace.bresp, exp_resp);
      @(posedge clk); #1;
      ace.bready = 1'b0;
      chk({tag, "_bvalid_drop"}, ace.bvalid, 0);
   endtask

   task automatic do_read(input string tag, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input bit toggle, input logic [1:0] exp_resp,
                          input bit zero_data);
      int idx, t, beat, cyc;
      bit acc;
      idx = int'(addr[9:6]);
      ace.arid = id; ace.araddr = addr; ace.arlen = 8'(len); ace.arvalid = 1'b1;
      t = 0;
      while (ace.arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      chk({tag, "_ar_timeout"}, line_t'(t < 50), 1);
      @(posedge clk); #1;
      ace.arvalid = 1'b0;
      chk({tag, "_rvalid_n1"}, ace.rvalid, 1);
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 200) begin
         ace.rready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (ace.rvalid === 1'b1) begin
            chk({tag, "_rdata"}, ace.rdata, zero_data ? '0 : model[(idx + beat) % DEPTH]);
            chk({tag, "_rlast"}, ace.rlast, line_t'(beat == len));
            chk({tag, "_rid"}, ace.rid, id);
            chk({tag, "_rresp"}, ace.rresp, exp_resp);
            chk({tag, "_arready_busy"}, ace.arready, 0);
            if (beat == len) last_rdata = ace.rdata;
         end
         acc = (ace.rvalid === 1'b1) && ace.rready;
         @(posedge clk); #1;
         cyc++;
         if (acc) beat++;
      end
      ace.rready = 1'b0;
      chk({tag, "_beats"}, beat, len + 1);
      chk({tag, "_rvalid_idle"}, ace.rvalid, 0);
      chk({tag, "_rdata_idle"}, ace.rdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_bus();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", ace.awready, 1);
      chk("rst_arready", ace.arready, 1);
      chk("rst_wready", ace.wready, 0);
      chk("rst_bvalid", ace.bvalid, 0);
      chk("rst_rvalid", ace.rvalid, 0);
      chk("rst_rlast", ace.rlast, 0);
      chk("rst_bresp", ace.bresp, RESP_OKAY);
      chk("rst_rresp", ace.rresp, RESP_OKAY);
      chk("rst_bid", ace.bid, 0);
      chk("rst_rid", ace.rid, 0);
      chk("rst_rdata", ace.rdata, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // single beat write/read at line 1
      do_write("wr_single", 4'h3, 32'h40, 0, BURST_INCR, 8'hA5, '1, 1'b0, RESP_OKAY, 1'b1);
      do_read("rd_single", 4'h5, 32'h40, 0, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_single_const", last_rdata, pat(8'hA5));

      // burst wrapping 14,15,0,1
      do_write("wr_wrap", 4'h7, 32'h380, 3, BURST_INCR, 8'h10, '1, 1'b0, RESP_OKAY, 1'b1);
      do_read("rd_wrap", 4'h2, 32'h380, 3, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_wrap_line1_const", last_rdata, pat(8'h13));

      // partial strobe on line 4
      do_write("wr_ff", 4'h1, 32'h100, 0, BURST_INCR, 8'hFF, '1, 1'b0, RESP_OKAY, 1'b1);
      do_write("wr_strb", 4'h1, 32'h100, 0, BURST_INCR, 8'h00, 64'h1, 1'b0, RESP_OKAY, 1'b1);
      do_read("rd_strb", 4'h4, 32'h100, 0, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_strb_const", last_rdata, {{63{8'hFF}}, 8'h00});

      // stalled 8-beat read with a concurrent independent write
      do_write("wr_fill", 4'h8, 32'h0, 7, BURST_INCR, 8'h20, '1, 1'b0, RESP_OKAY, 1'b1);
      fork
         do_read("rd_stall", 4'h9, 32'h0, 7, 1'b1, RESP_OKAY, 1'b0);
         do_write("wr_conc", 4'h4, 32'h280, 1, BURST_INCR, 8'h60, '1, 1'b0, RESP_OKAY, 1'b1);
      join
      chk("rd_stall_last_const", last_rdata, pat(8'h27));
      do_read("rd_conc", 4'h6, 32'h280, 1, 1'b0, RESP_OKAY, 1'b0);

      // reset on beat 2 of a 4-beat write at line 12
      ace.awid = 4'h6; ace.awaddr = 32'h300; ace.awlen = 8'd3; ace.awvalid = 1'b1;
      chk("midrst_awready", ace.awready, 1);
      @(posedge clk); #1;
      ace.awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         ace.wdata = pat(8'h80 + 8'(b)); ace.wstrb = '1; ace.wlast = 1'b0; ace.wvalid = 1'b1;
         chk("midrst_wready", ace.wready, 1);
         @(posedge clk); #1;
      end
      ace.wdata = pat(8'h82);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ace.wvalid = 1'b0;
      chk("midrst_bvalid", ace.bvalid, 0);
      chk("midrst_awready_after", ace.awready, 1);
      chk("midrst_wready_after", ace.wready, 0);
      model[12] = pat(8'h80);
      model[13] = pat(8'h81);
      do_write("wr_after_rst", 4'h1, 32'h300, 0, BURST_INCR, 8'hC3, '1, 1'b0, RESP_OKAY, 1'b1);
      do_read("rd_after_rst", 4'hE, 32'h300, 1, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_after_rst_kept_const", last_rdata, pat(8'h81));

      // bad burst, high address and wlast mismatch
      do_write("wr_badburst", 4'hA, 32'h40, 0, 2'b10, 8'h5A, '1, 1'b0,
               ERRCHK ? RESP_SLVERR : RESP_OKAY, !ERRCHK);
      do_read("rd_badburst_line", 4'hB, 32'h40, 0, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_badburst_const", last_rdata, ERRCHK ? pat(8'h21) : pat(8'h5A));
      do_read("rd_highaddr", 4'hC, 32'h10000, 0, 1'b0, ERRCHK ? RESP_SLVERR : RESP_OKAY, ERRCHK);
      do_write("wr_badlast", 4'hD, 32'h200, 1, BURST_INCR, 8'h70, '1, 1'b1,
               ERRCHK ? RESP_SLVERR : RESP_OKAY, 1'b1);
      do_read("rd_badlast", 4'h3, 32'h200, 1, 1'b0, RESP_OKAY, 1'b0);
      chk("rd_badlast_const", last_rdata, pat(8'h71));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ofs_fim_ace_lite_slv_mem.md
OFS_FIM_ACE_LITE_SLV_MEM -- requirements
Module: ofs_fim_ace_lite_slv_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of data lines in memory (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AW/AR address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, W/R data width; byte lanes = DATA_WIDTH/8.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port s_ace, ofs_fim_ace_lite_if.slave modport (AWADDR_WIDTH=ARADDR_WIDTH=ADDR_WIDTH, WDATA_WIDTH=RDATA_WIDTH=DATA_WIDTH), all five channels, responder side.
REQ-007 SHALL ignore awprot/arprot, awcache/arcache, awqos/arqos, awuser/aruser, awlock/arlock, awsnoop/arsnoop, awdomain/ardomain, awbar/arbar.

Function
REQ-008 Word index SHALL be addr[LSB +: log2(DEPTH)], LSB = log2(DATA_WIDTH/8); addr low LSB bits ignored.
REQ-009 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-010 On awvalid&&awready SHALL capture awid, word index, awlen and go W_IDLE->W_DATA; beat counter cleared.
REQ-011 Each wvalid&&wready beat SHALL write bytes with wstrb[i]=1 to current index, then increment index modulo DEPTH (wrap to 0 after DEPTH-1) and beat counter.
REQ-012 Beat with counter==len SHALL move W_DATA->W_RESP regardless of wlast; bid=captured awid.
REQ-013 W_RESP SHALL hold bvalid, bid, bresp stable until bready; on bvalid&&bready go W_RESP->W_IDLE, next awready no earlier than following cycle.
REQ-014 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; rvalid=1 only in R_DATA.
REQ-015 On arvalid&&arready (cycle N) SHALL capture arid, index, arlen; rvalid=1 at N+1 with first beat.
REQ-016 rdata SHALL be the line at current read index; rid=captured arid; rlast=1 iff beat counter==len; beats SHALL be back-to-back while rready=1.
REQ-017 rdata/rid/rlast/rresp SHALL stay stable while rvalid&&!rready; on rlast beat accepted go R_DATA->R_IDLE.
REQ-018 Read index SHALL wrap modulo DEPTH like writes.
REQ-019 Read and write FSMs SHALL be independent and concurrent; same-line read and write in one cycle SHALL return pre-write data.
REQ-020 One outstanding write and one outstanding read max; no AW/AR accepted while busy.
REQ-021 rdata SHALL read 0 when rvalid=0.

Reset
REQ-022 With rst=1 at a clock edge: FSMs to W_IDLE/R_IDLE; awready=1, arready=1 on the following cycle; wready, bvalid, rvalid, rlast=0; bresp, rresp=2'b00; bid, rid=0; rdata=0.
REQ-023 Reset mid-burst SHALL abandon the transaction with no response; bytes already written SHALL remain; memory contents are not reset.

Configuration
REQ-024 Macro OFS_ACE_LITE_SLV_ERR_CHK_EN SHALL enable response checking.
REQ-025 With macro defined: AW/AR with burst!=INCR(2'b01), size!=log2(DATA_WIDTH/8), or nonzero address bits above the memory span SHALL receive SLVERR (2'b10) on all R beats / on B; such writes SHALL not modify memory; such reads SHALL return rdata=0; wlast mismatch with counter==len SHALL set bresp=SLVERR (data still written).
REQ-026 Without macro: all responses OKAY (2'b00); high address bits, burst, size, wlast ignored.

Structure
REQ-027 Package ofs_fim_ace_lite_slv_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01, and write/read state enums.
REQ-028 Sub-module ofs_fim_ace_lite_slv_ram SHALL implement DEPTH x DATA_WIDTH byte-enabled array, one write port, one asynchronous read port.

Verification
REQ-029 Single write awaddr=0x40, awlen=0, wstrb all 1, wdata=0xA5.. then read araddr=0x40 arlen=0 -> bresp=OKAY, bid=awid; rdata=0xA5.., rlast=1 at N+1.
REQ-030 Write awlen=3 from line 14 (DEPTH=16) -> lines 14,15,0,1 written; read arlen=3 same address returns four beats in order, rlast on 4th only.
REQ-031 Partial strobe wstrb=0x1 over line of 0xFF.. with wdata=0x00.. -> read returns byte0=0x00, others 0xFF.
REQ-032 Read burst arlen=7 with rready toggling 1/0 each cycle -> 8 beats, payload stable during stalls, arready=0 until last accepted; concurrent write completes independently.
REQ-033 rst asserted mid-write burst (beat 2 of 4) -> next cycle bvalid=0, awready=1; new write completes normally.
REQ-034 With OFS_ACE_LITE_SLV_ERR_CHK_EN: awburst=2'b10 -> bresp=SLVERR, memory unchanged; araddr=0x10000 -> rresp=SLVERR, rdata=0; without macro same stimulus -> OKAY.
